ro_sched_gray: RTL and testbench



---
 rtl/ro_pkg.sv | 28 ++
 rtl/ro_slot_gen.sv | 46 ++++
 rtl/ro_sched_gray.sv | 112 +++++++++++
 tb/tb_ro_sched_gray.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared types and elaboration helpers for the Gray-code readout scheduler.
// Widths that depend on NUM_CH are computed per instance with these functions.
package ro_pkg;

    localparam int unsigned NUM_CH_MAX = 16;
    localparam int unsigned SLOT_W     = 5;

    // Wide enough for 0..NUM_CH_MAX so the idle marker never aliases a channel.
    typedef logic [SLOT_W-1:0] slot_idx_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned ch_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic slot_idx_t idle_slot(input int unsigned n);
        return slot_idx_t'(n);
    endfunction

endpackage

// File: rtl/ro_slot_gen.sv
// Binary slot counter with registered Gray view and trailing-zero slot encoder.
// slot/slot_valid describe the slot that the next advancing edge will serve.
module ro_slot_gen
    import ro_pkg::*;
#(
    parameter int unsigned NUM_CH = 8
) (
    input  logic              clk_master,
    input  logic              rstb,
    input  logic              en,
    output slot_idx_t         slot,
    output logic              slot_valid,
    output logic [NUM_CH-1:0] gray
);

    logic [NUM_CH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0] gray_q, gray_d;
    logic [NUM_CH-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt    = cnt_q + 1'b1;
        cnt_d      = en ? cnt_nxt : cnt_q;
        gray_d     = cnt_d ^ (cnt_d >> 1);
        slot_valid = (cnt_nxt != '0);
        slot       = idle_slot(NUM_CH);
        // Scanning high to low leaves the lowest set bit, i.e. the toggling Gray bit.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cnt_nxt[i]) begin
                slot = slot_idx_t'(i);
            end
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt_q  <= '0;
            gray_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
        end
    end

    assign gray = gray_q;

endmodule

// File: rtl/ro_sched_gray.sv
// Time-division readout scheduler: channel k is served whenever Gray bit k toggles.
// Holds per-channel pending/overflow state and the registered readout word.
module ro_sched_gray
    import ro_pkg::*;
#(
    parameter  int unsigned NUM_CH = 8,
    parameter  int unsigned DATA_W = 2,
    parameter  bit          STICKY = 1'b1,
    localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
    input  logic                     clk_master,
    input  logic                     rstb,
    input  logic                     en,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     ro_valid,
    output logic [CH_W-1:0]          ro_ch,
    output logic [DATA_W-1:0]        ro_data,
    output logic                     ro_ovf,
    output logic [NUM_CH-1:0]        gray_out
);

    slot_idx_t slot;
    logic      slot_valid;
    logic      serve;

    logic [NUM_CH-1:0][DATA_W-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0]             ovf_q, ovf_d;

    logic              ro_valid_q, ro_valid_d;
    logic [CH_W-1:0]   ro_ch_q, ro_ch_d;
    logic [DATA_W-1:0] ro_data_q, ro_data_d;
    logic              ro_ovf_q, ro_ovf_d;

    logic [DATA_W-1:0] sel_word;
    logic              sel_ovf;
    logic [DATA_W-1:0] in_w;
    logic              hit;

    ro_slot_gen #(
        .NUM_CH (NUM_CH)
    ) u_slot_gen (
        .clk_master (clk_master),
        .rstb       (rstb),
        .en         (en),
        .slot       (slot),
        .slot_valid (slot_valid),
        .gray       (gray_out)
    );

    assign serve = en && slot_valid;

    always_comb begin
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        sel_word = '0;
        sel_ovf  = 1'b0;
        in_w     = '0;
        hit      = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            in_w = in_data[k*DATA_W +: DATA_W];
            hit  = serve && (slot == slot_idx_t'(k));
            if (STICKY) begin
                // Events landing on the service edge go straight out rather than into pend.
                if (hit) begin
                    sel_word = pend_q[k] | in_w;
                    sel_ovf  = ovf_q[k];
                    pend_d[k] = '0;
                    ovf_d[k]  = 1'b0;
                end else begin
                    pend_d[k] = pend_q[k] | in_w;
                    ovf_d[k]  = ovf_q[k] | (|(pend_q[k] & in_w));
                end
            end else if (hit) begin
                sel_word = in_w;
            end
        end

        ro_valid_d = serve;
        ro_ch_d    = ro_ch_q;
        ro_data_d  = ro_data_q;
        ro_ovf_d   = 1'b0;
        if (serve) begin
            ro_ch_d   = CH_W'(slot);
            ro_data_d = sel_word;
            ro_ovf_d  = sel_ovf;
        end
    end

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            pend_q     <= '0;
            ovf_q      <= '0;
            ro_valid_q <= 1'b0;
            ro_ch_q    <= '0;
            ro_data_q  <= '0;
            ro_ovf_q   <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            ro_valid_q <= ro_valid_d;
            ro_ch_q    <= ro_ch_d;
            ro_data_q  <= ro_data_d;
            ro_ovf_q   <= ro_ovf_d;
        end
    end

    assign ro_valid = ro_valid_q;
    assign ro_ch    = ro_ch_q;
    assign ro_data  = ro_data_q;
    assign ro_ovf   = ro_ovf_q;

endmodule

// File: tb/tb_ro_sched_gray.sv
// Directed bench for ro_sched_gray at NUM_CH=4, DATA_W=2, with a sticky and a level-sample instance.
module tb_ro_sched_gray;

    logic       clk_master = 1'b0;
    logic       rstb;
    logic       en;
    logic [7:0] in_data;

    logic       s_valid, s_ovf, l_valid, l_ovf;
    logic [1:0] s_ch, s_data, l_ch, l_data;
    logic [3:0] s_gray, l_gray;

    int vec  = 0;
    int errs = 0;

    always #5 clk_master = ~clk_master;

    ro_sched_gray #(.NUM_CH(4), .DATA_W(2), .STICKY(1'b1)) dut (
        .clk_master (clk_master),
        .rstb       (rstb),
        .en         (en),
        .in_data    (in_data),
        .ro_valid   (s_valid),
        .ro_ch      (s_ch),
        .ro_data    (s_data),
        .ro_ovf     (s_ovf),
        .gray_out   (s_gray)
    );

    ro_sched_gray #(.NUM_CH(4), .DATA_W(2), .STICKY(1'b0)) dut_lvl (
        .clk_master (clk_master),
        .rstb       (rstb),
        .en         (en),
        .in_data    (in_data),
        .ro_valid   (l_valid),
        .ro_ch      (l_ch),
        .ro_data    (l_data),
        .ro_ovf     (l_ovf),
        .gray_out   (l_gray)
    );

    task automatic tick();
        @(posedge clk_master);
        #1;
    endtask

    task automatic apply_reset();
        rstb    = 1'b0;
        en      = 1'b0;
        in_data = '0;
        tick();
        tick();
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            en      = ~en;
            tick();
        end
        vec++; if (s_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", s_valid); end
        vec++; if (s_ch !== 2'd0) begin errs++; $display("FAIL rst_ch got %0d exp 0", s_ch); end
        vec++; if (s_data !== 2'd0) begin errs++; $display("FAIL rst_data got %b exp 00", s_data); end
        vec++; if (s_ovf !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b exp 0", s_ovf); end
        vec++; if (s_gray !== 4'd0) begin errs++; $display("FAIL rst_gray got %b exp 0000", s_gray); end
        vec++; if (l_valid !== 1'b0 || l_gray !== 4'd0) begin
            errs++; $display("FAIL rst_lvl got valid=%b gray=%b exp 0/0000", l_valid, l_gray);
        end

        // Leave a pending ch3 event, then reset asynchronously between edges.
        rstb    = 1'b1;
        en      = 1'b1;
        in_data = 8'b01_00_00_00;
        tick(); tick(); tick();
        in_data = '0;
        #2;
        rstb = 1'b0;
        #1;
        vec++; if (s_valid !== 1'b0) begin errs++; $display("FAIL async_rst_valid got %b exp 0", s_valid); end
        vec++; if (s_gray !== 4'd0) begin errs++; $display("FAIL async_rst_gray got %b exp 0000", s_gray); end
        vec++; if (s_ch !== 2'd0 || s_data !== 2'd0) begin
            errs++; $display("FAIL async_rst_word got ch=%0d data=%b exp 0/00", s_ch, s_data);
        end
        tick();
        rstb = 1'b1;
        en   = 1'b1;
        for (int e = 1; e <= 8; e++) tick();
        vec++; if (s_ch !== 2'd3 || s_data !== 2'b00) begin
            errs++; $display("FAIL rst_pend_clear got ch=%0d data=%b exp 3/00", s_ch, s_data);
        end
    endtask

    task automatic test_schedule();
        logic [1:0] exp_ch   [15];
        logic [3:0] exp_gray [16];
        logic [3:0] prev_gray;
        exp_ch   = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};
        exp_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                     4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        apply_reset();
        en        = 1'b1;
        prev_gray = 4'd0;
        for (int e = 0; e < 16; e++) begin
            tick();
            if (e < 15) begin
                vec++; if (s_valid !== 1'b1 || s_ch !== exp_ch[e]) begin
                    errs++; $display("FAIL sched edge=%0d got valid=%b ch=%0d exp 1/%0d", e + 1, s_valid, s_ch, exp_ch[e]);
                end
                vec++; if (l_ch !== exp_ch[e]) begin
                    errs++; $display("FAIL sched_lvl edge=%0d got ch=%0d exp %0d", e + 1, l_ch, exp_ch[e]);
                end
            end else begin
                vec++; if (s_valid !== 1'b0 || s_ch !== 2'd0) begin
                    errs++; $display("FAIL sched_idle got valid=%b ch=%0d exp 0/0", s_valid, s_ch);
                end
            end
            vec++; if (s_gray !== exp_gray[e]) begin
                errs++; $display("FAIL gray edge=%0d got %b exp %b", e + 1, s_gray, exp_gray[e]);
            end
            vec++; if ($countones(s_gray ^ prev_gray) != 1) begin
                errs++; $display("FAIL gray_step edge=%0d got %b after %b exp one-bit change", e + 1, s_gray, prev_gray);
            end
            prev_gray = s_gray;
        end
    endtask

    task automatic test_sticky_accum();
        apply_reset();
        en = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            in_data = (e == 1) ? 8'b01_00_00_00 : (e == 4) ? 8'b10_00_00_00 : 8'h00;
            tick();
        end
        in_data = '0;
        vec++; if (s_valid !== 1'b1 || s_ch !== 2'd3 || s_data !== 2'b11 || s_ovf !== 1'b0) begin
            errs++; $display("FAIL sticky_accum got v=%b ch=%0d data=%b ovf=%b exp 1/3/11/0", s_valid, s_ch, s_data, s_ovf);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        en = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            in_data = (e == 1 || e == 2) ? 8'b00_01_00_00 : 8'h00;
            tick();
            if (e == 4) begin
                vec++; if (s_ch !== 2'd2 || s_data !== 2'b01 || s_ovf !== 1'b1) begin
                    errs++; $display("FAIL ovf_set got ch=%0d data=%b ovf=%b exp 2/01/1", s_ch, s_data, s_ovf);
                end
                vec++; if (l_data !== 2'b00 || l_ovf !== 1'b0) begin
                    errs++; $display("FAIL ovf_lvl got data=%b ovf=%b exp 00/0", l_data, l_ovf);
                end
            end
            if (e == 12) begin
                vec++; if (s_ch !== 2'd2 || s_data !== 2'b00 || s_ovf !== 1'b0) begin
                    errs++; $display("FAIL ovf_clear got ch=%0d data=%b ovf=%b exp 2/00/0", s_ch, s_data, s_ovf);
                end
            end
        end
    endtask

    task automatic test_collision();
        apply_reset();
        en = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            in_data = (e == 3) ? 8'b00_00_00_10 : 8'h00;
            tick();
            if (e == 3) begin
                vec++; if (s_ch !== 2'd0 || s_data !== 2'b10) begin
                    errs++; $display("FAIL collide got ch=%0d data=%b exp 0/10", s_ch, s_data);
                end
                vec++; if (l_data !== 2'b10) begin
                    errs++; $display("FAIL collide_lvl got data=%b exp 10", l_data);
                end
            end
            if (e == 5) begin
                vec++; if (s_ch !== 2'd0 || s_data !== 2'b00) begin
                    errs++; $display("FAIL collide_pend got ch=%0d data=%b exp 0/00", s_ch, s_data);
                end
            end
        end
    endtask

    task automatic test_freeze();
        apply_reset();
        en = 1'b1;
        for (int e = 1; e <= 5; e++) tick();
        en = 1'b0;
        for (int f = 0; f < 4; f++) begin
            in_data = (f == 1) ? 8'b00_00_01_00 : 8'h00;
            tick();
            vec++; if (s_valid !== 1'b0 || l_valid !== 1'b0 || s_gray !== 4'b0111) begin
                errs++; $display("FAIL freeze f=%0d got v=%b lv=%b gray=%b exp 0/0/0111", f, s_valid, l_valid, s_gray);
            end
        end
        in_data = '0;
        en      = 1'b1;
        tick();
        vec++; if (s_valid !== 1'b1 || s_ch !== 2'd1 || s_data !== 2'b01 || s_gray !== 4'b0101) begin
            errs++; $display("FAIL resume got v=%b ch=%0d data=%b gray=%b exp 1/1/01/0101", s_valid, s_ch, s_data, s_gray);
        end
        vec++; if (l_ch !== 2'd1 || l_data !== 2'b00) begin
            errs++; $display("FAIL resume_lvl got ch=%0d data=%b exp 1/00", l_ch, l_data);
        end
    endtask

    task automatic test_level_sample();
        logic [1:0] exp_d [8];
        exp_d = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00};
        apply_reset();
        en = 1'b1;
        for (int e = 0; e < 8; e++) begin
            in_data = (e < 4) ? 8'hE4 : 8'h1B;
            tick();
            vec++; if (l_valid !== 1'b1 || l_data !== exp_d[e]) begin
                errs++; $display("FAIL level edge=%0d got v=%b data=%b exp 1/%b", e + 1, l_valid, l_data, exp_d[e]);
            end
        end
        in_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstb    = 1'b0;
        en      = 1'b0;
        in_data = '0;
        test_reset();
        test_schedule();
        test_sticky_accum();
        test_overflow();
        test_collision();
        test_freeze();
        test_level_sample();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
